// File: rtl/chipper_router_p.sv
// Bufferless deflection router for one mesh node.
// Four links plus a local port; every flit leaves one edge after capture.
module chipper_router_p #(
    parameter int DATA_W = 7,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MY_X   = 1,
    parameter int MY_Y   = 1,
    parameter int CNT_W  = 16,
    localparam int FLIT_W = 2 + X_W + Y_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_n,
    input  logic [FLIT_W-1:0] in_s,
    input  logic [FLIT_W-1:0] in_e,
    input  logic [FLIT_W-1:0] in_w,
    input  logic [FLIT_W-1:0] inj_flit,
    input  logic              inj_valid,
    output logic              inj_ready,
    output logic [FLIT_W-1:0] out_n,
    output logic [FLIT_W-1:0] out_s,
    output logic [FLIT_W-1:0] out_e,
    output logic [FLIT_W-1:0] out_w,
    output logic [FLIT_W-1:0] ej_flit,
    output logic [CNT_W-1:0]  deflect_cnt
);

    localparam int VB = FLIT_W - 1;
    localparam int GB = FLIT_W - 2;
    localparam int XH = FLIT_W - 3;
    localparam int YH = DATA_W + Y_W - 1;

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_E = 3'd1;
    localparam logic [2:0] P_S = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    localparam logic [FLIT_W-1:0] VMASK = {1'b1, {(FLIT_W-1){1'b0}}};

    logic [FLIT_W-1:0] s [4];
    logic [FLIT_W-1:0] f [4];
    logic [FLIT_W-1:0] po [4];
    logic [FLIT_W-1:0] ej_nxt;
    logic [1:0]        prio_ptr;
    logic [2:0]        ndef;
    logic              any_vld;

    function automatic logic [2:0] route(
        input logic [X_W-1:0] dx,
        input logic [Y_W-1:0] dy
    );
        logic [2:0] p;
        if (dx > X_W'(MY_X))      p = P_E;
        else if (dx < X_W'(MY_X)) p = P_W;
        else if (dy > Y_W'(MY_Y)) p = P_N;
        else if (dy < Y_W'(MY_Y)) p = P_S;
        else                      p = P_L;
        return p;
    endfunction

    // Golden slots first, each group in rotating order from ptr.
    function automatic logic [7:0] rank(
        input logic [3:0] gold,
        input logic [1:0] ptr
    );
        logic [7:0] ord;
        logic [2:0] k;
        logic [1:0] idx;
        ord = '0;
        k   = '0;
        for (int g = 1; g >= 0; g--) begin
            for (int i = 0; i < 4; i++) begin
                idx = ptr + 2'(i);
                if (gold[idx] == g[0]) begin
                    ord[2*k[1:0] +: 2] = idx;
                    k = k + 3'd1;
                end
            end
        end
        return ord;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s[0] <= '0;
            s[1] <= '0;
            s[2] <= '0;
            s[3] <= '0;
        end else begin
            s[0] <= in_n;
            s[1] <= in_e;
            s[2] <= in_s;
            s[3] <= in_w;
        end
    end

    always_comb begin
        logic [3:0] vld;
        logic [3:0] gold0;
        logic [3:0] gold1;
        logic [2:0] rt0 [4];
        logic [2:0] rt1 [4];
        logic [7:0] ord0;
        logic [7:0] ord1;
        logic [1:0] idx;
        logic [1:0] ej_idx;
        logic       ej_hit;
        logic       placed;
        logic [3:0] taken;
        logic [2:0] p;

        vld    = '0;
        gold0  = '0;
        gold1  = '0;
        ej_idx = '0;
        ej_hit = 1'b0;
        placed = 1'b0;
        taken  = '0;
        idx    = '0;
        p      = '0;
        ndef   = '0;
        inj_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld[i]   = s[i][VB];
            gold0[i] = s[i][GB];
            rt0[i]   = route(s[i][XH -: X_W], s[i][YH -: Y_W]);
            f[i]     = s[i];
            po[i]    = '0;
            rt1[i]   = P_L;
        end
        any_vld = |vld;

        ord0 = rank(gold0, prio_ptr);
        for (int r = 0; r < 4; r++) begin
            idx = ord0[2*r +: 2];
            if (!ej_hit && vld[idx] && rt0[idx] == P_L) begin
                ej_hit = 1'b1;
                ej_idx = idx;
            end
        end
        if (ej_hit) f[ej_idx] = '0;
        ej_nxt = ej_hit ? s[ej_idx] : '0;

        for (int i = 0; i < 4; i++)
            if (!f[i][VB]) inj_ready = 1'b1;

        if (inj_valid && inj_ready) begin
            for (int i = 0; i < 4; i++) begin
                if (!placed && !f[i][VB]) begin
                    f[i]   = inj_flit | VMASK;
                    placed = 1'b1;
                end
            end
        end

        for (int i = 0; i < 4; i++) begin
            gold1[i] = f[i][GB];
            rt1[i]   = route(f[i][XH -: X_W], f[i][YH -: Y_W]);
        end
        ord1 = rank(gold1, prio_ptr);

        // Productive port if free, else first free port in N,E,S,W.
        for (int r = 0; r < 4; r++) begin
            idx = ord1[2*r +: 2];
            if (f[idx][VB]) begin
                p = rt1[idx];
                if (p != P_L && !taken[p[1:0]]) begin
                    taken[p[1:0]] = 1'b1;
                    po[p[1:0]]    = f[idx];
                end else begin
                    placed = 1'b0;
                    for (int q = 0; q < 4; q++) begin
                        if (!placed && !taken[q]) begin
                            taken[q] = 1'b1;
                            po[q]    = f[idx];
                            placed   = 1'b1;
                        end
                    end
                    ndef = ndef + 3'd1;
                end
            end
        end
    end

    logic [CNT_W:0] cnt_sum;
    assign cnt_sum = {1'b0, deflect_cnt} + (CNT_W+1)'(ndef);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_n       <= '0;
            out_e       <= '0;
            out_s       <= '0;
            out_w       <= '0;
            ej_flit     <= '0;
            prio_ptr    <= '0;
            deflect_cnt <= '0;
        end else begin
            out_n   <= po[0];
            out_e   <= po[1];
            out_s   <= po[2];
            out_w   <= po[3];
            ej_flit <= ej_nxt;
            if (any_vld) prio_ptr <= prio_ptr + 2'd1;
            if (cnt_sum[CNT_W]) deflect_cnt <= '1;
            else                deflect_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_chipper_router_p.sv
// Directed bench for chipper_router_p.
// Hand-computed flits, checked with immediate assertions.
module tb_chipper_router_p;

    localparam int FW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_n, in_s, in_e, in_w;
    logic [FW-1:0] inj_flit;
    logic          inj_valid;
    logic          inj_ready;
    logic [FW-1:0] out_n, out_s, out_e, out_w;
    logic [FW-1:0] ej_flit;
    logic [3:0]    deflect_cnt;

    int total = 0;
    int bad   = 0;

    chipper_router_p #(
        .DATA_W(7), .X_W(2), .Y_W(2),
        .MY_X(1), .MY_Y(1), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_n(in_n), .in_s(in_s), .in_e(in_e), .in_w(in_w),
        .inj_flit(inj_flit), .inj_valid(inj_valid),
        .inj_ready(inj_ready),
        .out_n(out_n), .out_s(out_s), .out_e(out_e), .out_w(out_w),
        .ej_flit(ej_flit), .deflect_cnt(deflect_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] mk(
        input bit v, input bit g,
        input int x, input int y, input int p
    );
        return {v, g, 2'(x), 2'(y), 7'(p)};
    endfunction

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [FW-1:0] n, input logic [FW-1:0] e,
                        input logic [FW-1:0] s, input logic [FW-1:0] w);
        @(negedge clk);
        in_n = n; in_e = e; in_s = s; in_w = w;
        @(negedge clk);
        in_n = '0; in_e = '0; in_s = '0; in_w = '0;
        @(negedge clk);
    endtask

    task automatic inject(input logic [FW-1:0] fl);
        @(negedge clk);
        inj_valid = 1'b1;
        inj_flit  = fl;
        #1 chk("inj_ready_idle", 16'(inj_ready), 16'd1);
        @(negedge clk);
        inj_valid = 1'b0;
        inj_flit  = '0;
    endtask

    logic [FW-1:0] e0, e1, e2, e3;

    initial begin
        rst = 1'b1;
        in_n = '0; in_s = '0; in_e = '0; in_w = '0;
        inj_flit = '0; inj_valid = 1'b0;
        e0 = mk(1, 0, 3, 0, 7'h31);
        e1 = mk(1, 0, 3, 0, 7'h32);
        e2 = mk(1, 0, 3, 0, 7'h33);
        e3 = mk(1, 0, 3, 0, 7'h34);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_out_e", 16'(out_e), 16'd0);
        chk("rst_ej", 16'(ej_flit), 16'd0);
        chk("rst_cnt", 16'(deflect_cnt), 16'd0);
        chk("rst_ready", 16'(inj_ready), 16'd1);

        // eastbound pass-through, ptr 0 -> 1
        send('0, mk(1, 0, 3, 1, 7'h05), '0, '0);
        chk("t1_out_e", 16'(out_e), 16'(mk(1, 0, 3, 1, 7'h05)));
        chk("t1_out_n", 16'(out_n), 16'd0);
        chk("t1_out_s", 16'(out_s), 16'd0);
        chk("t1_out_w", 16'(out_w), 16'd0);
        chk("t1_ej", 16'(ej_flit), 16'd0);
        chk("t1_cnt", 16'(deflect_cnt), 16'd0);

        // local eject, ptr 1 -> 2
        send(mk(1, 0, 1, 1, 7'h2A), '0, '0, '0);
        chk("t2_ej", 16'(ej_flit), 16'(mk(1, 0, 1, 1, 7'h2A)));
        chk("t2_outs", 16'(out_n | out_e | out_s | out_w), 16'd0);
        chk("t2_cnt", 16'(deflect_cnt), 16'd0);

        // golden local wins eject, ptr 2 -> 3
        send(mk(1, 0, 1, 1, 7'h11), '0, mk(1, 1, 1, 1, 7'h22), '0);
        chk("t3_ej", 16'(ej_flit), 16'(mk(1, 1, 1, 1, 7'h22)));
        chk("t3_out_n", 16'(out_n), 16'(mk(1, 0, 1, 1, 7'h11)));
        chk("t3_rest", 16'(out_e | out_s | out_w), 16'd0);
        chk("t3_cnt", 16'(deflect_cnt), 16'd1);

        // four eastbound, ptr 3 ranks W first; inject refused
        @(negedge clk);
        in_n = e0; in_e = e1; in_s = e2; in_w = e3;
        inj_valid = 1'b1;
        inj_flit  = mk(0, 0, 3, 1, 7'h7F);
        @(negedge clk);
        chk("t4_ready", 16'(inj_ready), 16'd0);
        in_n = '0; in_e = '0; in_s = '0; in_w = '0;
        @(negedge clk);
        inj_valid = 1'b0;
        inj_flit  = '0;
        chk("t4_out_e", 16'(out_e), 16'(e3));
        chk("t4_out_n", 16'(out_n), 16'(e0));
        chk("t4_out_s", 16'(out_s), 16'(e1));
        chk("t4_out_w", 16'(out_w), 16'(e2));
        chk("t4_cnt", 16'(deflect_cnt), 16'd4);
        @(negedge clk);
        chk("t4_drain", 16'(out_n | out_e | out_s | out_w), 16'd0);

        // inject into empty node, one-edge latency, ptr holds at 0
        inject(mk(0, 0, 3, 1, 7'h55));
        chk("inj_out_e", 16'(out_e), 16'(mk(1, 0, 3, 1, 7'h55)));
        chk("inj_cnt", 16'(deflect_cnt), 16'd4);

        inject(mk(0, 0, 1, 1, 7'h66));
        chk("self_out_n", 16'(out_n), 16'(mk(1, 0, 1, 1, 7'h66)));
        chk("self_ej", 16'(ej_flit), 16'd0);
        chk("self_cnt", 16'(deflect_cnt), 16'd5);

        // two golden locals: ptr 0 then ptr 1 decides
        send(mk(1, 1, 1, 1, 7'h41), mk(1, 1, 1, 1, 7'h42), '0, '0);
        chk("g0_ej", 16'(ej_flit), 16'(mk(1, 1, 1, 1, 7'h41)));
        chk("g0_out_n", 16'(out_n), 16'(mk(1, 1, 1, 1, 7'h42)));
        chk("g0_cnt", 16'(deflect_cnt), 16'd6);
        send(mk(1, 1, 1, 1, 7'h41), mk(1, 1, 1, 1, 7'h42), '0, '0);
        chk("g1_ej", 16'(ej_flit), 16'(mk(1, 1, 1, 1, 7'h42)));
        chk("g1_out_n", 16'(out_n), 16'(mk(1, 1, 1, 1, 7'h41)));
        chk("g1_cnt", 16'(deflect_cnt), 16'd7);

        // fill the counter to 14, then saturate
        send(e0, e1, e2, e3);
        chk("fill_cnt10", 16'(deflect_cnt), 16'd10);
        send(e0, e1, e2, e3);
        chk("fill_cnt13", 16'(deflect_cnt), 16'd13);
        inject(mk(0, 0, 1, 1, 7'h01));
        chk("fill_cnt14", 16'(deflect_cnt), 16'd14);
        send(e0, e1, e2, e3);
        chk("sat_cnt15", 16'(deflect_cnt), 16'd15);
        send(e0, e1, e2, e3);
        chk("sat_hold", 16'(deflect_cnt), 16'd15);

        // reset with flits in flight
        @(negedge clk);
        in_n = e0; in_e = e1; in_s = e2; in_w = e3;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_vld", 16'(out_e[FW-1]), 16'd1);
        rst = 1'b1;
        #1;
        chk("rst_now_outs", 16'(out_n | out_e | out_s | out_w), 16'd0);
        chk("rst_now_cnt", 16'(deflect_cnt), 16'd0);
        in_n = '0; in_e = '0; in_s = '0; in_w = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst1", 16'(out_n | out_e | out_s | out_w | ej_flit), 16'd0);
        @(negedge clk);
        chk("post_rst2", 16'(out_n | out_e | out_s | out_w | ej_flit), 16'd0);
        chk("post_rst_cnt", 16'(deflect_cnt), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
